// File: rtl/player_damage_control.sv
// player_damage_control
//   Converts the registered per-cycle trigger-collision flag into player HP
//   loss. After each hit it opens an invincibility window (i-frames) during
//   which the sprite blinks. When HP reaches zero it latches game over.
//
// Ports
//   clk               system clock
//   clk_reset         synchronous active-low reset
//   is_trigger_player player overlaps a damaging object this cycle
//   game_restart      one-cycle pulse: restore full HP, leave DEAD
//   player_hp         current HP, 0..MAX_HP
//   hp_changed        one-cycle pulse on every HP change
//   invincible        high while i-frames are active
//   player_visible    sprite enable, blinks during i-frames
//   game_over         high while dead
module player_damage_control #(
  parameter int MAX_HP       = 92,
  parameter int DAMAGE       = 1,
  parameter int TICK_DIV     = 1_000_000,
  parameter int IFRAME_TICKS = 100
) (
  input  logic       clk,
  input  logic       clk_reset,
  input  logic       is_trigger_player,
  input  logic       game_restart,
  output logic [6:0] player_hp,
  output logic       hp_changed,
  output logic       invincible,
  output logic       player_visible,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(IFRAME_TICKS + 1);

  localparam logic [6:0]    HP_FULL  = 7'(MAX_HP);
  localparam logic [6:0]    HP_DMG   = 7'(DAMAGE);
  localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IF_LOAD  = IW'(IFRAME_TICKS);

  generate
    if (MAX_HP < 1 || MAX_HP > 127)   begin : g_bad_hp  $error("MAX_HP out of range");  end
    if (DAMAGE < 1 || DAMAGE > 127)   begin : g_bad_dmg $error("DAMAGE out of range");  end
    if (IFRAME_TICKS < 1)             begin : g_bad_if  $error("IFRAME_TICKS < 1");     end
    if (TICK_DIV < 1)                 begin : g_bad_td  $error("TICK_DIV < 1");         end
  endgenerate

  typedef enum logic [1:0] {IDLE, COOLDOWN, DEAD} state_t;

  state_t        state,      state_nxt;
  logic [6:0]    hp,         hp_nxt;
  logic          chg,        chg_nxt;
  logic          vis,        vis_nxt;
  logic [TW-1:0] tick_cnt,   tick_nxt;
  logic [IW-1:0] iframe_cnt, iframe_nxt;

  always_ff @(posedge clk) begin
    if (!clk_reset) begin
      state      <= IDLE;
      hp         <= HP_FULL;
      chg        <= 1'b0;
      vis        <= 1'b1;
      tick_cnt   <= '0;
      iframe_cnt <= '0;
    end else begin
      state      <= state_nxt;
      hp         <= hp_nxt;
      chg        <= chg_nxt;
      vis        <= vis_nxt;
      tick_cnt   <= tick_nxt;
      iframe_cnt <= iframe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hp_nxt     = hp;
    chg_nxt    = 1'b0;
    vis_nxt    = vis;
    tick_nxt   = tick_cnt;
    iframe_nxt = iframe_cnt;

    if (game_restart) begin
      // restart wins over a same-cycle trigger; that trigger is dropped
      state_nxt  = IDLE;
      hp_nxt     = HP_FULL;
      chg_nxt    = 1'b1;
      vis_nxt    = 1'b1;
      tick_nxt   = '0;
      iframe_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_trigger_player) begin
            chg_nxt = 1'b1;
            // compare before subtract so HP saturates at 0 instead of wrapping
            if (hp > HP_DMG) begin
              hp_nxt     = hp - HP_DMG;
              state_nxt  = COOLDOWN;
              iframe_nxt = IF_LOAD;
              tick_nxt   = '0;
              vis_nxt    = 1'b0;
            end else begin
              hp_nxt    = '0;
              state_nxt = DEAD;
              vis_nxt   = 1'b1;
            end
          end
        end
        COOLDOWN: begin
          // triggers ignored; window length is exactly IFRAME_TICKS*TICK_DIV
          if (tick_cnt == TICK_END) begin
            tick_nxt   = '0;
            iframe_nxt = iframe_cnt - IW'(1);
            vis_nxt    = ~vis;
            if (iframe_cnt == IW'(1)) begin
              state_nxt = IDLE;
              vis_nxt   = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        DEAD: begin
          vis_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign player_hp      = hp;
  assign hp_changed     = chg;
  assign player_visible = vis;
  assign invincible     = (state == COOLDOWN);
  assign game_over      = (state == DEAD);

endmodule

// File: tb/tb_player_damage_control.sv
module tb_player_damage_control;

  localparam int WIN = 12; // IFRAME_TICKS * TICK_DIV for the bench parameters

  logic       clk = 1'b0;
  logic       clk_reset = 1'b0;
  logic       is_trigger_player = 1'b0;
  logic       game_restart = 1'b0;
  logic [6:0] player_hp;
  logic       hp_changed, invincible, player_visible, game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int hp;
    logic chg, inv, vis, go;
  } exp_t;

  exp_t sb[$];

  player_damage_control #(
    .MAX_HP(5), .DAMAGE(2), .TICK_DIV(4), .IFRAME_TICKS(3)
  ) dut (
    .clk(clk),
    .clk_reset(clk_reset),
    .is_trigger_player(is_trigger_player),
    .game_restart(game_restart),
    .player_hp(player_hp),
    .hp_changed(hp_changed),
    .invincible(invincible),
    .player_visible(player_visible),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, total, obs, expv);
    end
  endtask

  // drive one cycle of stimulus, queue its expected outputs, compare after the edge
  task automatic step(input logic trig, input logic rst_go, input logic rst_n,
                      input int hp, input logic chg, input logic inv,
                      input logic vis, input logic go);
    exp_t e;
    is_trigger_player = trig;
    game_restart      = rst_go;
    clk_reset         = rst_n;
    e.hp = hp; e.chg = chg; e.inv = inv; e.vis = vis; e.go = go;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("player_hp",      int'(player_hp),      e.hp);
      chk("hp_changed",     int'(hp_changed),     int'(e.chg));
      chk("invincible",     int'(invincible),     int'(e.inv));
      chk("player_visible", int'(player_visible), int'(e.vis));
      chk("game_over",      int'(game_over),      int'(e.go));
    end
  endtask

  function automatic logic vis_at(input int i);
    if (i >= WIN) return 1'b1;
    return ((i / 4) % 2) == 1;
  endfunction

  // cycles k+1..k+12 after a hit at k; trig_mask bit i drives the trigger at k+i
  task automatic cd_window(input int hp, input logic [12:0] trig_mask);
    for (int i = 1; i <= WIN; i++)
      step(trig_mask[i], 1'b0, 1'b1, hp, 1'b0, (i < WIN), vis_at(i), 1'b0);
  endtask

  initial begin
    // reset held 3 cycles, then release
    repeat (3) step(0, 0, 0, 5, 0, 0, 1, 0);
    step(0, 0, 1, 5, 0, 0, 1, 0);

    // hit, ignored triggers at k+2, k+11 and the expiry cycle k+12, hit at k+13
    step(1, 0, 1, 3, 1, 1, 0, 0);
    cd_window(3, 13'b1_1000_0000_0100);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    // held trigger: saturating from 1 into DEAD
    cd_window(1, 13'h1FFE);
    step(1, 0, 1, 0, 1, 0, 1, 1);
    repeat (2) step(1, 0, 1, 0, 0, 0, 1, 1);

    // restart with trigger high: restart wins, next cycle trigger hits
    step(1, 1, 1, 5, 1, 0, 1, 0);
    step(1, 0, 1, 3, 1, 1, 0, 0);
    cd_window(3, 13'h1FFE);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    cd_window(1, 13'h1FFE);
    step(1, 0, 1, 0, 1, 0, 1, 1);

    // restart without trigger, hp_changed drops next cycle
    step(0, 1, 1, 5, 1, 0, 1, 0);
    step(0, 0, 1, 5, 0, 0, 1, 0);

    // reset mid-COOLDOWN at k+5, trigger right after release is accepted
    step(1, 0, 1, 3, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 3, 0, 1, vis_at(i), 0);
    step(0, 0, 0, 5, 0, 0, 1, 0);
    step(1, 0, 1, 3, 1, 1, 0, 0);
    step(0, 0, 1, 3, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
